// File: rtl/sprite_mover.sv
// Moves a sprite by STEP pixels per request, clamped to the map, then streams a full
// row-major redraw of the sprite. Optional macro LINK_FACING_EN adds a facing field to rom_addr.
module sprite_mover #(
    parameter int SPR_W  = 16,
    parameter int SPR_H  = 16,
    parameter int MAP_W  = 256,
    parameter int MAP_H  = 176,
    parameter int STEP   = 1,
    parameter int X_INIT = 120,
    parameter int Y_INIT = 80,
    localparam int PIX_AW = $clog2(SPR_W * SPR_H),
`ifdef LINK_FACING_EN
    localparam int ROM_AW = PIX_AW + 2
`else
    localparam int ROM_AW = PIX_AW
`endif
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              init,
    input  logic              move_char,
    input  logic [3:0]        dir,
    output logic [7:0]        x_draw,
    output logic [6:0]        y_draw,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              VGA_write,
    output logic              draw_done,
    output logic              busy,
    output logic [7:0]        x_pos,
    output logic [6:0]        y_pos
);

    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    // Bounds are also capped to what the 8-bit x / 7-bit y position can hold.
    localparam int X_LIM = MAP_W - SPR_W;
    localparam int Y_LIM = MAP_H - SPR_H;
    localparam int X_MAX = (X_LIM > 255) ? 255 : X_LIM;
    localparam int Y_MAX = (Y_LIM > 127) ? 127 : Y_LIM;

    typedef enum logic [1:0] {IDLE, UPDATE, DRAW, DONE} state_t;

    state_t            state_reg, state_next;
    logic [3:0]        dir_reg;
    logic [7:0]        x_pos_reg, x_pos_next;
    logic [6:0]        y_pos_reg, y_pos_next;
    logic [CW-1:0]     col_reg;
    logic [RW-1:0]     row_reg;
    logic [PIX_AW-1:0] idx_reg;
    logic [7:0]        x_hold_reg;
    logic [6:0]        y_hold_reg;
    logic [ROM_AW-1:0] addr_hold_reg;
    logic [7:0]        x_live;
    logic [6:0]        y_live;
    logic [ROM_AW-1:0] addr_live;
    logic              drawing;
    logic              last_pixel;

`ifdef LINK_FACING_EN
    logic [1:0] facing_reg, facing_next;

    always_comb begin
        facing_next = facing_reg;
        if (state_reg == UPDATE) begin
            if (dir_reg[3])      facing_next = 2'd1;
            else if (dir_reg[2]) facing_next = 2'd0;
            else if (dir_reg[1]) facing_next = 2'd2;
            else if (dir_reg[0]) facing_next = 2'd3;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || init) facing_reg <= 2'd0;
        else               facing_reg <= facing_next;
    end

    assign addr_live = {facing_reg, idx_reg};
`else
    assign addr_live = idx_reg;
`endif

    assign drawing    = (state_reg == DRAW);
    assign last_pixel = (col_reg == CW'(SPR_W - 1)) && (row_reg == RW'(SPR_H - 1));
    assign x_live     = x_pos_reg + 8'(col_reg);
    assign y_live     = y_pos_reg + 7'(row_reg);

    assign VGA_write = drawing;
    assign x_draw    = drawing ? x_live : x_hold_reg;
    assign y_draw    = drawing ? y_live : y_hold_reg;
    assign rom_addr  = drawing ? addr_live : addr_hold_reg;
    assign draw_done = (state_reg == DONE) && !init;
    assign busy      = (state_reg != IDLE);
    assign x_pos     = x_pos_reg;
    assign y_pos     = y_pos_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (move_char) state_next = UPDATE;
            UPDATE:  state_next = DRAW;
            DRAW:    if (last_pixel) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (init) state_next = IDLE;
    end

    // Opposing requests on one axis cancel; each axis clamps independently.
    always_comb begin
        x_pos_next = x_pos_reg;
        y_pos_next = y_pos_reg;
        if (state_reg == UPDATE) begin
            if (dir_reg[1] && !dir_reg[0])
                x_pos_next = (int'(x_pos_reg) >= STEP) ? 8'(int'(x_pos_reg) - STEP) : 8'd0;
            else if (dir_reg[0] && !dir_reg[1])
                x_pos_next = (int'(x_pos_reg) + STEP >= X_MAX) ? 8'(X_MAX) : 8'(int'(x_pos_reg) + STEP);
            if (dir_reg[3] && !dir_reg[2])
                y_pos_next = (int'(y_pos_reg) >= STEP) ? 7'(int'(y_pos_reg) - STEP) : 7'd0;
            else if (dir_reg[2] && !dir_reg[3])
                y_pos_next = (int'(y_pos_reg) + STEP >= Y_MAX) ? 7'(Y_MAX) : 7'(int'(y_pos_reg) + STEP);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            dir_reg       <= 4'd0;
            x_pos_reg     <= 8'(X_INIT);
            y_pos_reg     <= 7'(Y_INIT);
            col_reg       <= '0;
            row_reg       <= '0;
            idx_reg       <= '0;
            x_hold_reg    <= 8'd0;
            y_hold_reg    <= 7'd0;
            addr_hold_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && move_char) dir_reg <= dir;
            if (drawing) begin
                x_hold_reg    <= x_live;
                y_hold_reg    <= y_live;
                addr_hold_reg <= addr_live;
            end
            if (init) begin
                x_pos_reg <= 8'(X_INIT);
                y_pos_reg <= 7'(Y_INIT);
                col_reg   <= '0;
                row_reg   <= '0;
                idx_reg   <= '0;
            end else begin
                x_pos_reg <= x_pos_next;
                y_pos_reg <= y_pos_next;
                if (drawing) begin
                    if (last_pixel) begin
                        col_reg <= '0;
                        row_reg <= '0;
                        idx_reg <= '0;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                        if (col_reg == CW'(SPR_W - 1)) begin
                            col_reg <= '0;
                            row_reg <= row_reg + 1'b1;
                        end else begin
                            col_reg <= col_reg + 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_mover.sv
// Self-checking bench for sprite_mover: table of single-move passes on a default-size
// instance, plus hand-written abort/ignore sequences and a clamp run on a small instance.
`timescale 1ns/1ps
module tb_sprite_mover;

`ifdef LINK_FACING_EN
    localparam int FW = 2;
`else
    localparam int FW = 0;
`endif

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // Default-size instance
    logic          init1, move1;
    logic [3:0]    dir1;
    logic [7:0]    x_draw1, x_pos1;
    logic [6:0]    y_draw1, y_pos1;
    logic [7+FW:0] rom_addr1;
    logic          vga1, done1, busy1;

    // Small instance for clamp runs: 4x4 sprite, STEP 2, x bound 240
    logic          init2, move2;
    logic [3:0]    dir2;
    logic [7:0]    x_draw2, x_pos2;
    logic [6:0]    y_draw2, y_pos2;
    logic [3+FW:0] rom_addr2;
    logic          vga2, done2, busy2;

    sprite_mover dut1 (
        .clock(clock), .reset(reset), .init(init1), .move_char(move1), .dir(dir1),
        .x_draw(x_draw1), .y_draw(y_draw1), .rom_addr(rom_addr1), .VGA_write(vga1),
        .draw_done(done1), .busy(busy1), .x_pos(x_pos1), .y_pos(y_pos1)
    );

    sprite_mover #(.SPR_W(4), .SPR_H(4), .MAP_W(244), .STEP(2)) dut2 (
        .clock(clock), .reset(reset), .init(init2), .move_char(move2), .dir(dir2),
        .x_draw(x_draw2), .y_draw(y_draw2), .rom_addr(rom_addr2), .VGA_write(vga2),
        .draw_done(done2), .busy(busy2), .x_pos(x_pos2), .y_pos(y_pos2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] dir;
        int         ex;
        int         ey;
        int         ef;
    } vec_t;

    vec_t vecs[9];

    // One full pass on dut1: checks latency, write count, pixel order and final position.
    task automatic run_pass1(input logic [3:0] d, input int ex, input int ey, input int ef);
        int writes, first_cyc, done_cyc, seq_err;
        writes = 0; first_cyc = -1; done_cyc = -1; seq_err = 0;
        @(negedge clock);
        dir1 = d; move1 = 1'b1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clock);
            if (cyc == 1) begin move1 = 1'b0; dir1 = ~d; end
            if (vga1 === 1'b1) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (x_draw1 !== 8'(ex + writes % 16) || y_draw1 !== 7'(ey + writes / 16) ||
                    int'(rom_addr1) != writes + ef * 256 * (FW / 2))
                    seq_err++;
                writes++;
            end
            if (done1 === 1'b1) begin done_cyc = cyc; break; end
        end
        check("first_pixel_cycle", 64'(first_cyc), 64'd2);
        check("draw_done_cycle", 64'(done_cyc), 64'd258);
        check("write_count", 64'(writes), 64'd256);
        check("pixel_sequence_errors", 64'(seq_err), 64'd0);
        check("x_pos", 64'(x_pos1), 64'(ex));
        check("y_pos", 64'(y_pos1), 64'(ey));
        check("x_draw_hold", 64'(x_draw1), 64'(ex + 15));
        check("y_draw_hold", 64'(y_draw1), 64'(ey + 15));
        @(negedge clock);
        check("busy_after_pass", 64'(busy1), 64'd0);
        check("done_one_cycle", 64'(done1), 64'd0);
        dir1 = 4'd0;
        $display("pass dir=%b x=%0d y=%0d writes=%0d first@%0d done@%0d",
                 d, x_pos1, y_pos1, writes, first_cyc, done_cyc);
    endtask

    // One pass on dut2; only completion and write count are checked here.
    task automatic run_pass2(input logic [3:0] d);
        int writes, got_done;
        writes = 0; got_done = 0;
        @(negedge clock);
        dir2 = d; move2 = 1'b1;
        @(negedge clock);
        move2 = 1'b0;
        for (int cyc = 2; cyc <= 60 && got_done == 0; cyc++) begin
            @(negedge clock);
            if (vga2 === 1'b1) writes++;
            if (done2 === 1'b1) got_done = 1;
        end
        check("small_pass_done", 64'(got_done), 64'd1);
        check("small_pass_writes", 64'(writes), 64'd16);
        $display("small pass dir=%b x=%0d y=%0d writes=%0d", d, x_pos2, y_pos2, writes);
    endtask

    initial begin
        int n_done;
        vecs[0] = '{4'b0001, 121, 80, 3};
        vecs[1] = '{4'b0010, 120, 80, 2};
        vecs[2] = '{4'b1000, 120, 79, 1};
        vecs[3] = '{4'b0100, 120, 80, 0};
        vecs[4] = '{4'b1100, 120, 80, 1};
        vecs[5] = '{4'b0011, 120, 80, 2};
        vecs[6] = '{4'b0000, 120, 80, 2};
        vecs[7] = '{4'b1001, 121, 79, 1};
        vecs[8] = '{4'b0110, 120, 80, 0};

        reset = 1'b1; init1 = 1'b0; move1 = 1'b0; dir1 = 4'd0;
        init2 = 1'b0; move2 = 1'b0; dir2 = 4'd0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        check("reset_x_pos", 64'(x_pos1), 64'd120);
        check("reset_y_pos", 64'(y_pos1), 64'd80);
        check("reset_x_draw", 64'(x_draw1), 64'd0);
        check("reset_y_draw", 64'(y_draw1), 64'd0);
        check("reset_rom_addr", 64'(rom_addr1), 64'd0);
        check("reset_vga_write", 64'(vga1), 64'd0);
        check("reset_draw_done", 64'(done1), 64'd0);
        check("reset_busy", 64'(busy1), 64'd0);
        check("reset_small_draw", 64'({x_draw2, y_draw2, rom_addr2}), 64'd0);
        check("reset_small_busy", 64'(busy2), 64'd0);

        for (int i = 0; i < 9; i++)
            run_pass1(vecs[i].dir, vecs[i].ex, vecs[i].ey, vecs[i].ef);

        // move_char during DRAW must not start a second pass
        n_done = 0;
        @(negedge clock);
        dir1 = 4'b0001; move1 = 1'b1;
        for (int cyc = 1; cyc <= 600; cyc++) begin
            @(negedge clock);
            if (done1 === 1'b1) n_done++;
            move1 = (cyc == 50);
            if (cyc == 50) dir1 = 4'b0010;
        end
        dir1 = 4'd0;
        check("move_during_draw_done_count", 64'(n_done), 64'd1);
        check("move_during_draw_x_pos", 64'(x_pos1), 64'd121);
        $display("ignore-move seq: done_count=%0d x=%0d", n_done, x_pos1);

        // init mid-DRAW: back to spawn, idle, no draw_done
        n_done = 0;
        @(negedge clock);
        dir1 = 4'b0001; move1 = 1'b1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clock);
            move1 = 1'b0;
            if (done1 === 1'b1) n_done++;
            if (cyc == 60) init1 = 1'b1;
            if (cyc == 61) begin
                init1 = 1'b0;
                check("init_vga_write", 64'(vga1), 64'd0);
                check("init_busy", 64'(busy1), 64'd0);
                check("init_x_pos", 64'(x_pos1), 64'd120);
            end
        end
        dir1 = 4'd0;
        check("init_no_draw_done", 64'(n_done), 64'd0);
        $display("init-abort seq: done_count=%0d x=%0d", n_done, x_pos1);

        // reset at pixel 100: writes stop next cycle, no draw_done, position back to spawn
        n_done = 0;
        @(negedge clock);
        dir1 = 4'b0001; move1 = 1'b1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clock);
            move1 = 1'b0;
            if (done1 === 1'b1) n_done++;
            if (cyc == 102) begin
                check("pixel100_rom_addr", 64'(rom_addr1), 64'(100 + 3 * 256 * (FW / 2)));
                check("pixel100_x_pos", 64'(x_pos1), 64'd121);
                reset = 1'b1;
            end
            if (cyc == 103) begin
                reset = 1'b0;
                check("reset_abort_vga_write", 64'(vga1), 64'd0);
                check("reset_abort_x_pos", 64'(x_pos1), 64'd120);
                check("reset_abort_busy", 64'(busy1), 64'd0);
                check("reset_abort_x_draw", 64'(x_draw1), 64'd0);
            end
        end
        dir1 = 4'd0;
        check("reset_abort_no_draw_done", 64'(n_done), 64'd0);
        $display("reset-abort seq: done_count=%0d x=%0d", n_done, x_pos1);

        // Clamp runs on the small instance
        @(negedge clock); init2 = 1'b1;
        @(negedge clock); init2 = 1'b0;
        check("small_init_x", 64'(x_pos2), 64'd120);
        for (int i = 0; i < 120; i++) run_pass2(4'b0010);
        check("clamp_left_x", 64'(x_pos2), 64'd0);
        run_pass2(4'b0010);
        check("clamp_left_again_x", 64'(x_pos2), 64'd0);
        for (int i = 0; i < 200; i++) run_pass2(4'b0001);
        check("clamp_right_x", 64'(x_pos2), 64'd240);
        for (int i = 0; i < 30; i++) run_pass2(4'b0100);
        check("clamp_down_y", 64'(y_pos2), 64'd127);
        for (int i = 0; i < 70; i++) run_pass2(4'b1000);
        check("clamp_up_y", 64'(y_pos2), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_mover.md
SPRITE_MOVER -- requirements
Module: sprite_mover

Interface
REQ-001 SHALL have parameter SPR_W, default 16, sprite width in pixels.
REQ-002 SHALL have parameter SPR_H, default 16, sprite height in pixels.
REQ-003 SHALL have parameter MAP_W, default 256, and MAP_H, default 176, map bounds in pixels.
REQ-004 SHALL have parameter STEP, default 1, pixels moved per accepted move.
REQ-005 SHALL have parameters X_INIT, default 120, and Y_INIT, default 80, spawn position.
REQ-006 SHALL have port clock, input, 1, rising-edge clock.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have port init, input, 1, respawn sprite at X_INIT,Y_INIT.
REQ-009 SHALL have port move_char, input, 1, start one move-and-draw pass.
REQ-010 SHALL have port dir, input, 4, {up,down,left,right} request.
REQ-011 SHALL have port x_draw, output, 8, and y_draw, output, 7, pixel write coordinates.
REQ-012 SHALL have port rom_addr, output, clog2(SPR_W*SPR_H) (+2 with LINK_FACING_EN), sprite ROM address.
REQ-013 SHALL have port VGA_write, output, 1, pixel write strobe.
REQ-014 SHALL have port draw_done, output, 1, one-cycle pass-complete pulse.
REQ-015 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-016 SHALL have ports x_pos, output, 8, and y_pos, output, 7, current top-left sprite position.

Function
REQ-017 FSM states SHALL be IDLE, UPDATE, DRAW, DONE.
REQ-018 IDLE->UPDATE on move_char=1; move_char SHALL be ignored in any other state.
REQ-019 UPDATE: one cycle; dir sampled at acceptance cycle and held for the pass.
REQ-020 Horizontal: left-only gives x = max(x-STEP,0); right-only gives x = min(x+STEP,MAP_W-SPR_W); left+right gives no x change.
REQ-021 Vertical: same rule with up/down, bound MAP_H-SPR_H, 7-bit arithmetic with no wrap-around.
REQ-022 DRAW: SPR_W*SPR_H cycles, row-major; each cycle VGA_write=1, x_draw=x_pos+col, y_draw=y_pos+row, rom_addr=row*SPR_W+col.
REQ-023 After last pixel (col=SPR_W-1,row=SPR_H-1) SHALL go to DONE; DONE asserts draw_done for exactly one cycle, then IDLE.
REQ-024 Latency: move_char accepted at cycle 0, first pixel at cycle 2, draw_done at cycle SPR_W*SPR_H+2.
REQ-025 VGA_write SHALL be 0 outside DRAW; x_draw, y_draw, rom_addr hold last value outside DRAW.
REQ-026 init=1 in any state SHALL set position to X_INIT,Y_INIT, clear counters, go IDLE next cycle, no draw_done pulse; init has priority over move_char.
REQ-027 dir=0 SHALL still perform a full redraw pass at unchanged position.

Reset
REQ-028 reset SHALL take priority over init and move_char.
REQ-029 Reset values: state IDLE, x_pos=X_INIT, y_pos=Y_INIT, counters 0, x_draw=0, y_draw=0, rom_addr=0, VGA_write=0, draw_done=0, busy=0.
REQ-030 reset mid-DRAW SHALL abort the pass with no further writes and no draw_done.

Configuration
REQ-031 Macro LINK_FACING_EN defined: 2-bit facing register (down=0, up=1, left=2, right=3), updated in UPDATE from nonzero dir with priority up>down>left>right, reset/init to down; rom_addr = {facing, pixel index}.
REQ-032 LINK_FACING_EN undefined: no facing register; rom_addr = pixel index only.

Verification
REQ-033 reset, move_char with dir=0001 -> x_pos 121, y_pos 80, 256 VGA_write cycles, first pixel (121,80), last (136,95), draw_done at cycle 258.
REQ-034 init, then 120 moves with dir=0010 -> x_pos 0; next left move keeps 0; 200 right moves -> x_pos 240 (clamp).
REQ-035 dir=1100 and dir=0011 -> position unchanged, full redraw pass still occurs.
REQ-036 move_char pulsed during DRAW -> ignored, exactly one draw_done; reset at pixel 100 -> VGA_write 0 next cycle, no draw_done, x_pos=120.
REQ-037 LINK_FACING_EN, dir=0010 -> rom_addr upper bits 2, first address 0x200; without macro first address 0x000.
